// File: rtl/generador_spawn_x_pkg.sv
// Shared defaults and FSM encoding for the falling-cube spawn lane selector.
package generador_spawn_x_pkg;

    localparam int NUM_LANES_DEF  = 8;
    localparam int RAND_W_DEF     = 5;
    localparam int POS_W_DEF      = 9;
    localparam int LANE_PITCH_DEF = 64;
    localparam int NO_REPEAT_DEF  = 1;
    localparam int COOLDOWN_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_COOL = 2'd3
    } estado_t;

endpackage

// File: rtl/generador_spawn_x_escala_carril.sv
// Scales a random value onto a lane index and applies the no-repeat bump.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module escala_carril
    import generador_spawn_x_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int RAND_W    = RAND_W_DEF,
    parameter int NO_REPEAT = NO_REPEAT_DEF
) (
    input  logic [RAND_W-1:0]            aleatorio,
    input  logic [$clog2(NUM_LANES)-1:0] last_lane,
    input  logic                         last_valid,
    output logic [$clog2(NUM_LANES)-1:0] start
);

    localparam int LW = $clog2(NUM_LANES);
    localparam int PW = RAND_W + LW;

    logic [PW-1:0] prod;
    logic [LW-1:0] cand;

    // Product upper bits give floor(a*NL/2^RAND_W), always below NUM_LANES.
    always_comb begin
        prod = PW'(aleatorio) * PW'(NUM_LANES);
        cand = prod[PW-1:RAND_W];
        if (NO_REPEAT != 0 && last_valid && cand == last_lane)
            start = (cand == LW'(NUM_LANES - 1)) ? '0 : cand + LW'(1);
        else
            start = cand;
    end

endmodule

// File: rtl/generador_spawn_x.sv
// Spawn x-position generator: picks a free lane starting from a random one.
// Latency: 2 cycles from req when the start lane is free, +1 per skipped lane.
// Backpressure: result held on valid until ack; req ignored outside IDLE.
module generador_spawn_x
    import generador_spawn_x_pkg::*;
#(
    parameter int NUM_LANES  = NUM_LANES_DEF,
    parameter int RAND_W     = RAND_W_DEF,
    parameter int POS_W      = POS_W_DEF,
    parameter int LANE_PITCH = LANE_PITCH_DEF,
    parameter int NO_REPEAT  = NO_REPEAT_DEF,
    parameter int COOLDOWN   = COOLDOWN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [RAND_W-1:0]            aleatorio,
    input  logic [NUM_LANES-1:0]         carril_ocu,
    input  logic                         req,
    input  logic                         ack,
    output logic                         valid,
    output logic [POS_W-1:0]             posicion,
    output logic [$clog2(NUM_LANES)-1:0] carril,
    output logic                         sin_lugar,
    output logic                         ocupado
);

    localparam int LW        = $clog2(NUM_LANES);
    localparam int CW        = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int COOL_LAST = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

    estado_t               state_q, state_d;
    logic [LW-1:0]         idx_q, cnt_q, last_lane_q, start, idx_next;
    logic [NUM_LANES-1:0]  snap_q;
    logic                  last_valid_q;
    logic [CW-1:0]         cool_q;
    logic [POS_W-1:0]      pos_calc;
    logic                  lane_free, last_cnt;
    logic                  accept, grant, give_up, advance, release_hold;

    escala_carril #(
        .NUM_LANES (NUM_LANES),
        .RAND_W    (RAND_W),
        .NO_REPEAT (NO_REPEAT)
    ) u_escala (
        .aleatorio  (aleatorio),
        .last_lane  (last_lane_q),
        .last_valid (last_valid_q),
        .start      (start)
    );

    assign lane_free = ~snap_q[idx_q];
    assign last_cnt  = (cnt_q == LW'(NUM_LANES - 1));
    assign idx_next  = (idx_q == LW'(NUM_LANES - 1)) ? '0 : idx_q + LW'(1);
    assign pos_calc  = POS_W'(int'(idx_q) * LANE_PITCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_SCAN;
            ST_SCAN: if (lane_free || last_cnt) state_d = ST_HOLD;
            ST_HOLD: if (ack) state_d = (COOLDOWN > 0) ? ST_COOL : ST_IDLE;
            ST_COOL: if (cool_q == CW'(COOL_LAST)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ocupado      = (state_q != ST_IDLE);
        accept       = (state_q == ST_IDLE) && req;
        grant        = (state_q == ST_SCAN) && lane_free;
        give_up      = (state_q == ST_SCAN) && !lane_free && last_cnt;
        advance      = (state_q == ST_SCAN) && !lane_free && !last_cnt;
        release_hold = (state_q == ST_HOLD) && ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            snap_q       <= '0;
            last_lane_q  <= '0;
            last_valid_q <= 1'b0;
            cool_q       <= '0;
            valid        <= 1'b0;
            posicion     <= '0;
            carril       <= '0;
            sin_lugar    <= 1'b0;
        end else begin
            // Occupancy is frozen at acceptance so the scan sees a consistent view.
            if (accept) begin
                idx_q  <= start;
                cnt_q  <= '0;
                snap_q <= carril_ocu;
            end
            if (advance) begin
                idx_q <= idx_next;
                cnt_q <= cnt_q + LW'(1);
            end
            if (grant) begin
                valid        <= 1'b1;
                sin_lugar    <= 1'b0;
                posicion     <= pos_calc;
                carril       <= idx_q;
                last_lane_q  <= idx_q;
                last_valid_q <= 1'b1;
            end
            if (give_up) begin
                valid     <= 1'b1;
                sin_lugar <= 1'b1;
                posicion  <= '0;
                carril    <= '0;
            end
            if (release_hold) begin
                valid     <= 1'b0;
                sin_lugar <= 1'b0;
                cool_q    <= '0;
            end else if (state_q == ST_COOL) begin
                cool_q <= cool_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_generador_spawn_x.sv
// Directed bench for generador_spawn_x with default parameters.
module tb_generador_spawn_x;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] aleatorio;
    logic [7:0] carril_ocu;
    logic       req, ack;
    logic       valid, sin_lugar, ocupado;
    logic [8:0] posicion;
    logic [2:0] carril;

    int total = 0;
    int bad   = 0;

    generador_spawn_x dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .aleatorio  (aleatorio),
        .carril_ocu (carril_ocu),
        .req        (req),
        .ack        (ack),
        .valid      (valid),
        .posicion   (posicion),
        .carril     (carril),
        .sin_lugar  (sin_lugar),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise req for one accepting edge, scramble occupancy during the scan, wait for valid.
    task automatic spawn(input string tag, input logic [4:0] a, input logic [7:0] occ,
                         input int exp_lat, input int exp_carril, input int exp_pos,
                         input logic exp_sl);
        int n;
        aleatorio  = a;
        carril_ocu = occ;
        req        = 1'b1;
        n          = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                req        = 1'b0;
                carril_ocu = ~occ;
            end
        end while (!valid && n < 20);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_carril"}, carril, exp_carril);
        chk({tag, "_pos"}, posicion, exp_pos);
        chk({tag, "_sinlugar"}, sin_lugar, exp_sl);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_ack_valid"}, valid, 0);
        chk({tag, "_ack_busy"}, ocupado, 1);
        tick();
        tick();
        chk({tag, "_idle"}, ocupado, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        aleatorio  = '0;
        carril_ocu = '0;
        req        = 1'b0;
        ack        = 1'b0;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_pos", posicion, 0);
        chk("rst_carril", carril, 0);
        chk("rst_sinlugar", sin_lugar, 0);
        chk("rst_ocupado", ocupado, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Lanes 3..5 busy, start at 3 -> skip three, grant lane 6
        spawn("skip3", 5'd13, 8'b0011_1000, 5, 6, 384, 1'b0);
        do_ack("skip3");
        spawn("free", 5'd13, 8'h00, 2, 3, 192, 1'b0);
        do_ack("free");
        spawn("allbusy", 5'd0, 8'hFF, 9, 0, 0, 1'b1);
        do_ack("allbusy");
        spawn("top", 5'd31, 8'h00, 2, 7, 448, 1'b0);
        do_ack("top");
        spawn("norep", 5'd28, 8'h00, 2, 0, 0, 1'b0);
        do_ack("norep");
        spawn("top2", 5'd31, 8'h00, 2, 7, 448, 1'b0);
        do_ack("top2");

        // Reset in the middle of a scan
        aleatorio  = 5'd0;
        carril_ocu = 8'hFF;
        req        = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("scan_busy", ocupado, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_ocupado", ocupado, 0);
        chk("midrst_carril", carril, 0);
        tick();
        rst_n = 1'b1;
        spawn("postrst", 5'd31, 8'h00, 2, 7, 448, 1'b0);

        // req during cooldown is dropped
        ack = 1'b1;
        tick();
        ack = 1'b0;
        req = 1'b1;
        chk("cool1_busy", ocupado, 1);
        chk("cool1_valid", valid, 0);
        tick();
        req = 1'b0;
        chk("cool2_busy", ocupado, 1);
        tick();
        chk("cool_end_idle", ocupado, 0);
        tick();
        chk("noqueue_idle", ocupado, 0);
        chk("noqueue_valid", valid, 0);
        spawn("aftercool", 5'd5, 8'h00, 2, 1, 64, 1'b0);

        // req with ack in HOLD ignored, but a held req fires once IDLE returns
        aleatorio  = 5'd16;
        carril_ocu = 8'h00;
        ack        = 1'b1;
        req        = 1'b1;
        tick();
        ack = 1'b0;
        chk("held_cool_busy", ocupado, 1);
        chk("held_cool_valid", valid, 0);
        tick();
        tick();
        chk("held_idle", ocupado, 0);
        tick();
        req = 1'b0;
        chk("held_scan", ocupado, 1);
        tick();
        chk("held_valid", valid, 1);
        chk("held_carril", carril, 4);
        chk("held_pos", posicion, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
